// File: rtl/vedic_mult_pipe.sv
// Pipelined WIDTH x WIDTH Vedic (Urdhva-Tiryagbhyam) multiplier with signed/unsigned
// mode, a pass-through tag and a valid/ready handshake on both sides.

// Recursive vertical-crosswise core: splits into four half-width products down to 2x2 cells.
module vedic_core #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);
  generate
    if (N == 2) begin : g_cell
      logic t1, t2, c1, t3;
      assign t1 = x[1] & y[0];
      assign t2 = x[0] & y[1];
      assign c1 = t1 & t2;
      assign t3 = x[1] & y[1];
      assign p  = {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    end else begin : g_split
      localparam int unsigned H = N / 2;
      logic [N-1:0] hh, hl, lh, ll;
      logic [N:0]   mid;

      vedic_core #(.N(H)) u_hh (.x(x[N-1:H]), .y(y[N-1:H]), .p(hh));
      vedic_core #(.N(H)) u_hl (.x(x[N-1:H]), .y(y[H-1:0]), .p(hl));
      vedic_core #(.N(H)) u_lh (.x(x[H-1:0]), .y(y[N-1:H]), .p(lh));
      vedic_core #(.N(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(ll));

      assign mid = {1'b0, hl} + {1'b0, lh};
      assign p   = {hh, {N{1'b0}}}
                 + {{(H-1){1'b0}}, mid, {H{1'b0}}}
                 + {{N{1'b0}}, ll};
    end
  endgenerate
endmodule

module vedic_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] c,
  output logic [TAG_W-1:0]   tag_out,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  // Stage 1: sign and magnitudes
  logic             v1_q, v1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic             neg1_q, neg1_d;
  logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d;
  // Stage 2: sub-products
  logic             v2_q, v2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic             neg2_q, neg2_d;
  logic [WIDTH-1:0] hh_q, hh_d, hl_q, hl_d, lh_q, lh_d, ll_q, ll_d;
  // Stage 3: result
  logic             v3_q, v3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  logic [PW-1:0]    c_q, c_d;

  logic             adv_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] hh_c, hl_c, lh_c, ll_c;
  logic [WIDTH:0]   mid_c;
  logic [PW-1:0]    p_c;

  assign adv_c    = !v3_q | out_ready;
  assign in_ready = adv_c;

  // Most negative operand maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign a_mag_c = (signed_mode & a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
  assign b_mag_c = (signed_mode & b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

  vedic_core #(.N(HW)) u_hh (.x(ma_q[WIDTH-1:HW]), .y(mb_q[WIDTH-1:HW]), .p(hh_c));
  vedic_core #(.N(HW)) u_hl (.x(ma_q[WIDTH-1:HW]), .y(mb_q[HW-1:0]),     .p(hl_c));
  vedic_core #(.N(HW)) u_lh (.x(ma_q[HW-1:0]),     .y(mb_q[WIDTH-1:HW]), .p(lh_c));
  vedic_core #(.N(HW)) u_ll (.x(ma_q[HW-1:0]),     .y(mb_q[HW-1:0]),     .p(ll_c));

  assign mid_c = {1'b0, hl_q} + {1'b0, lh_q};
  assign p_c   = {hh_q, {WIDTH{1'b0}}}
               + {{(HW-1){1'b0}}, mid_c, {HW{1'b0}}}
               + {{WIDTH{1'b0}}, ll_q};

  // All three stages move together; a stalled output freezes the whole pipe.
  always_comb begin
    v1_d   = v1_q;   tag1_d = tag1_q; neg1_d = neg1_q; ma_d = ma_q; mb_d = mb_q;
    v2_d   = v2_q;   tag2_d = tag2_q; neg2_d = neg2_q;
    hh_d   = hh_q;   hl_d   = hl_q;   lh_d   = lh_q;   ll_d = ll_q;
    v3_d   = v3_q;   tag3_d = tag3_q; c_d    = c_q;
    if (adv_c) begin
      v1_d   = in_valid;
      tag1_d = tag_in;
      neg1_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      ma_d   = a_mag_c;
      mb_d   = b_mag_c;
      v2_d   = v1_q;
      tag2_d = tag1_q;
      neg2_d = neg1_q;
      hh_d   = hh_c;
      hl_d   = hl_c;
      lh_d   = lh_c;
      ll_d   = ll_c;
      v3_d   = v2_q;
      tag3_d = tag2_q;
      c_d    = neg2_q ? ({PW{1'b0}} - p_c) : p_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0; tag1_q <= '0; neg1_q <= 1'b0; ma_q <= '0; mb_q <= '0;
      v2_q <= 1'b0; tag2_q <= '0; neg2_q <= 1'b0;
      hh_q <= '0;   hl_q   <= '0; lh_q   <= '0;   ll_q <= '0;
      v3_q <= 1'b0; tag3_q <= '0; c_q    <= '0;
    end else begin
      v1_q <= v1_d; tag1_q <= tag1_d; neg1_q <= neg1_d; ma_q <= ma_d; mb_q <= mb_d;
      v2_q <= v2_d; tag2_q <= tag2_d; neg2_q <= neg2_d;
      hh_q <= hh_d; hl_q   <= hl_d;   lh_q   <= lh_d;   ll_q <= ll_d;
      v3_q <= v3_d; tag3_q <= tag3_d; c_q    <= c_d;
    end
  end

  assign c         = c_q;
  assign tag_out   = tag3_q;
  assign out_valid = v3_q;
endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-bit Vedic multiplier.
- WIDTH x WIDTH multiply built from four (WIDTH/2 x WIDTH/2) Urdhva-Tiryagbhyam sub-products, then summed.
- Three register stages with a valid/ready handshake on both sides and backpressure.
- Per-transaction signed/unsigned mode and a pass-through tag; used wherever the datapath needs a multiplier that can be timed at speed.

Parameters:
- WIDTH, 8: operand width; power of two, 4..32; product is 2*WIDTH bits.
- TAG_W, 4: width of the user tag carried alongside each operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = a, b, c two's complement; 0 = unsigned.
- tag_in  input  TAG_W  user tag, returned unchanged with the result.
- in_valid  input  1  a/b/signed_mode/tag_in valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- c  output  2*WIDTH  product.
- tag_out  output  TAG_W  tag of the operation on c.
- out_valid  output  1  c/tag_out valid.
- out_ready  input  1  downstream accepts c this cycle.

Behaviour:
- Global advance: adv = !out_valid | out_ready. in_ready = adv, combinational, with no dependence on in_valid.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready.
- S1 (capture, when adv):
  - Register valid, tag and sign flag neg = signed_mode & (a[W-1] ^ b[W-1]).
  - Register magnitudes: |a|, |b| in signed mode, else a, b.
  - |-2^(W-1)| = 2^(W-1) is representable as a WIDTH-bit unsigned value.
- S2 (when adv): register the four sub-products of the magnitude halves, each WIDTH bits: hh, hl, lh, ll.
  - Sub-products use the same vertical-crosswise recursion down to 2x2 cells, combinational within the stage.
- S3 (when adv):
  - p = (hh << W) + ((hl + lh) << W/2) + ll, computed at 2*WIDTH bits.
  - c = neg ? -p : p.
  - out_valid <= S2 valid.
- Pipeline:
  - Latency: exactly 3 clk edges from input transfer to out_valid, with no stall in between.
  - Throughput: 1 result per cycle while out_ready = 1.
  - Bubbles (invalid stages) advance like data; there is no bubble collapsing.
- Stall: out_valid=1 & out_ready=0 freezes all three stages. c, tag_out and out_valid hold stable, and in_ready=0.
- Simultaneous out transfer and in transfer in the same cycle is legal and expected.
- Result ranges:
  - Unsigned range: 0 .. (2^W-1)^2; never overflows 2*WIDTH.
  - Signed range: -2^(2W-2)+2^(W-1) .. 2^(2W-2); always representable.
- Zero operand in signed mode with neg=1 yields c=0, not negative zero.
- Reset (rst_n=0 at a clock edge), any time including mid-stall:
  - All stage valids and out_valid go to 0; c=0 and tag_out=0.
  - Data registers are cleared.
  - in_ready=1 in the first cycle after reset is released.
  - In-flight operations are discarded and never emitted.
- in_valid=0 with in_ready=1 inserts a bubble; a, b and tag_in are don't-care.

Test Plan:
- Unsigned, WIDTH=8, a=255, b=255, out_ready=1 -> 3 cycles later out_valid=1, c=65025 (0xFE01), tag_out equals tag_in.
- Back-to-back unsigned (153,47), (31,63), (0,200), one per cycle -> c=7191, 1953, 0 on three consecutive cycles; tags in order.
- Signed (-128,-128), (-1,127), (-128,127), (0,-5) -> c=0x4000, 0xFF81, 0xC080, 0x0000.
- Backpressure: stream 5 ops, hold out_ready=0 for 4 cycles after the first result -> c and tag_out stable, in_ready=0 while stalled. After release, all 5 results arrive in order with no loss or duplication.
- Reset mid-flight: 2 ops in the pipe, rst_n=0 for one edge -> out_valid=0, c=0 next cycle; the discarded ops never appear; a new op (3,5) returns c=15 after 3 cycles.
- WIDTH=16 instance: random 1000 signed/unsigned ops with random out_ready -> every c matches the reference product with the matching tag.
